// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the hex nibble-to-glyph decoder.
// Segment order is {g,f,e,d,c,b,a}; every glyph is active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;   // lowercase b
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;   // lowercase d
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph lookup for the currently scanned digit; blank forces all segments off.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : nibble_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment scanner with PWM brightness and frame-synchronous data update.
// Optional digit blinking is compiled in with SEG7_BLINK_EN.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int REFRESH_RATE = 1000,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_HZ     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int SLOT  = CLK_FREQ / (REFRESH_RATE * NUM_DIGITS);
    localparam int SUB   = SLOT / (2 ** PWM_BITS);
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);

    if (SUB < 1) begin : g_bad_cfg
        $error("seg7_scanner: CLK_FREQ too low for REFRESH_RATE, NUM_DIGITS and PWM_BITS");
    end

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] digits;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
    } disp_t;

    logic [SUB_W-1:0]      sub_cnt_q, sub_cnt_d;
    logic [PWM_BITS-1:0]   pwm_idx_q, pwm_idx_d;
    logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
    disp_t                 shadow_q, shadow_d, act_q, act_d;
    logic                  pending_q, pending_d, xfer_q, xfer_d;
    logic [6:0]            seg_q, seg_d, glyph_seg;
    logic                  dp_n_q, dp_n_d, frame_start_q, frame_start_d, load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  wrap, blank_eff, blink_off;

    assign wrap = (sub_cnt_q == SUB_W'(SUB - 1)) && (&pwm_idx_q)
               && (dig_idx_q == DIG_W'(NUM_DIGITS - 1));

    always_comb begin
        sub_cnt_d = sub_cnt_q + 1'b1;
        pwm_idx_d = pwm_idx_q;
        dig_idx_d = dig_idx_q;
        if (sub_cnt_q == SUB_W'(SUB - 1)) begin
            sub_cnt_d = '0;
            pwm_idx_d = pwm_idx_q + 1'b1;
            if (&pwm_idx_q)
                dig_idx_d = (dig_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
        end
    end

    // Active data only moves at the frame boundary; a load on that same cycle stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        act_d     = act_q;
        xfer_d    = wrap && pending_q;
        if (xfer_d)
            act_d = shadow_q;
        if (load) begin
            shadow_d.digits = digits;
            shadow_d.dp     = dp;
            shadow_d.blank  = blank;
            pending_d       = 1'b1;
        end else if (wrap) begin
            pending_d = 1'b0;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] mask_sh_q, mask_sh_d, mask_act_q, mask_act_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        mask_sh_d  = load ? blink_mask : mask_sh_q;
        mask_act_d = xfer_d ? mask_sh_q : mask_act_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            mask_sh_q   <= '0;
            mask_act_q  <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mask_sh_q   <= mask_sh_d;
            mask_act_q  <= mask_act_d;
        end
    end

    assign blink_off = mask_act_q[dig_idx_q] & ~phase_q;
`else
    localparam int blink_hz_unused = BLINK_HZ;
    logic blink_mask_unused;
    assign blink_mask_unused = ^blink_mask;
    assign blink_off         = 1'b0;
`endif

    assign blank_eff = act_q.blank[dig_idx_q] | blink_off;

    seg7_glyph u_glyph (
        .nibble (act_q.digits[dig_idx_q]),
        .blank  (blank_eff),
        .seg    (glyph_seg)
    );

    always_comb begin
        seg_d  = glyph_seg;
        dp_n_d = ~(act_q.dp[dig_idx_q] & ~blank_eff);
        an_d   = '1;
        // The top PWM subslot never lights, leaving a dead gap between digits.
        if (pwm_idx_q < brightness)
            an_d[dig_idx_q] = 1'b0;
        frame_start_d = (sub_cnt_q == '0) && (pwm_idx_q == '0) && (dig_idx_q == '0);
        load_ack_d    = xfer_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt_q       <= '0;
            pwm_idx_q       <= '0;
            dig_idx_q       <= '0;
            shadow_q        <= '0;
            pending_q       <= 1'b0;
            xfer_q          <= 1'b0;
            act_q.digits    <= '0;
            act_q.dp        <= '0;
            act_q.blank     <= '1;
            seg_q           <= SEG_BLANK;
            dp_n_q          <= 1'b1;
            an_q            <= '1;
            frame_start_q   <= 1'b0;
            load_ack_q      <= 1'b0;
        end else begin
            sub_cnt_q       <= sub_cnt_d;
            pwm_idx_q       <= pwm_idx_d;
            dig_idx_q       <= dig_idx_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            xfer_q          <= xfer_d;
            act_q           <= act_d;
            seg_q           <= seg_d;
            dp_n_q          <= dp_n_d;
            an_q            <= an_d;
            frame_start_q   <= frame_start_d;
            load_ack_q      <= load_ack_d;
        end
    end

    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;
    assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner: 4 digits, 16-cycle slots of 4 PWM subslots x 4 cycles.
// Blink checks run only when SEG7_BLINK_EN is defined.
module tb_seg7_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink_mask = '0;
    logic [1:0]  brightness = '0;
    logic        load = 1'b0;
    logic        load_ack, frame_start, dp_n;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    seg7_scanner #(
        .NUM_DIGITS   (4),
        .CLK_FREQ     (1600),
        .REFRESH_RATE (25),
        .PWM_BITS     (2),
        .BLINK_HZ     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame;
        for (int i = 0; i < 200; i++) begin
            if (frame_start === 1'b1) break;
            step;
        end
        chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    // Checks one 16-cycle digit slot starting at its first output cycle.
    task automatic check_slot(input int d, input logic [6:0] s, input logic dpn, input int on);
        logic [3:0] exp_an;
        for (int i = 0; i < 16; i++) begin
            exp_an = 4'hF;
            if (i < on) exp_an[d] = 1'b0;
            chk("slot_an", {28'd0, an}, {28'd0, exp_an});
            chk("slot_seg", {25'd0, seg}, {25'd0, s});
            chk("slot_dp_n", {31'd0, dp_n}, {31'd0, dpn});
            step;
        end
    endtask

    task automatic load_pulse(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits = d; dp = p; blank = b; load = 1'b1;
        step;
        load = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) step;
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp_n", {31'd0, dp_n}, 32'd1);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_load_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);

        rst = 1'b0;
        step;
        chk("first_frame_start", {31'd0, frame_start}, 32'd1);
        chk("first_no_ack", {31'd0, load_ack}, 32'd0);

        // load 12AF at full brightness
        brightness = 2'd3;
        load_pulse(16'h12AF, 4'b0000, 4'b0000);
        wait_frame;
        chk("ack_12af", {31'd0, load_ack}, 32'd1);
        check_slot(0, 7'h0E, 1'b1, 12);
        check_slot(1, 7'h08, 1'b1, 12);
        check_slot(2, 7'h24, 1'b1, 12);
        check_slot(3, 7'h79, 1'b1, 12);
        chk("frame_period", {31'd0, frame_start}, 32'd1);
        chk("no_repeat_ack", {31'd0, load_ack}, 32'd0);

        // brightness 1 then 0
        brightness = 2'd1;
        step;
        wait_frame;
        check_slot(0, 7'h0E, 1'b1, 4);
        check_slot(1, 7'h08, 1'b1, 4);
        check_slot(2, 7'h24, 1'b1, 4);
        check_slot(3, 7'h79, 1'b1, 4);
        brightness = 2'd0;
        step;
        wait_frame;
        check_slot(0, 7'h0E, 1'b1, 0);
        check_slot(1, 7'h08, 1'b1, 0);
        check_slot(2, 7'h24, 1'b1, 0);
        check_slot(3, 7'h79, 1'b1, 0);

        // two loads mid-frame: last one wins, single ack
        brightness = 2'd3;
        step;
        wait_frame;
        repeat (10) step;
        load_pulse(16'h1111, 4'b0000, 4'b0000);
        repeat (5) step;
        load_pulse(16'h2222, 4'b0000, 4'b0000);
        digits = 16'h0000;
        chk("no_tear", {25'd0, seg}, 32'h08);
        wait_frame;
        chk("ack_2222", {31'd0, load_ack}, 32'd1);
        check_slot(0, 7'h24, 1'b1, 12);
        check_slot(1, 7'h24, 1'b1, 12);
        check_slot(2, 7'h24, 1'b1, 12);
        check_slot(3, 7'h24, 1'b1, 12);
        chk("single_ack_fs", {31'd0, frame_start}, 32'd1);
        chk("single_ack", {31'd0, load_ack}, 32'd0);

        // load 3333 mid-frame, then 4444 exactly on the wrap cycle
        load_pulse(16'h3333, 4'b0000, 4'b0000);
        repeat (61) step;
        load_pulse(16'h4444, 4'b0000, 4'b0000);
        step;
        chk("wrap_fs", {31'd0, frame_start}, 32'd1);
        chk("wrap_ack1", {31'd0, load_ack}, 32'd1);
        check_slot(0, 7'h30, 1'b1, 12);
        check_slot(1, 7'h30, 1'b1, 12);
        check_slot(2, 7'h30, 1'b1, 12);
        check_slot(3, 7'h30, 1'b1, 12);
        chk("wrap_fs2", {31'd0, frame_start}, 32'd1);
        chk("wrap_ack2", {31'd0, load_ack}, 32'd1);
        check_slot(0, 7'h19, 1'b1, 12);

        // blank and decimal points
        load_pulse(16'h5678, 4'b0110, 4'b0100);
        wait_frame;
        chk("ack_5678", {31'd0, load_ack}, 32'd1);
        check_slot(0, 7'h00, 1'b1, 12);
        check_slot(1, 7'h78, 1'b0, 12);
        check_slot(2, 7'h7F, 1'b1, 12);
        check_slot(3, 7'h12, 1'b1, 12);

        // reset mid-frame with data pending
        repeat (20) step;
        load_pulse(16'h9999, 4'b0000, 4'b0000);
        repeat (3) step;
        rst = 1'b1;
        #1;
        chk("async_seg", {25'd0, seg}, 32'h7F);
        chk("async_dp_n", {31'd0, dp_n}, 32'd1);
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_load_ack", {31'd0, load_ack}, 32'd0);
        chk("async_frame_start", {31'd0, frame_start}, 32'd0);
        repeat (2) step;
        rst = 1'b0;
        step;
        chk("restart_fs", {31'd0, frame_start}, 32'd1);
        chk("restart_seg", {25'd0, seg}, 32'h7F);
        repeat (64) step;
        chk("restart_fs2", {31'd0, frame_start}, 32'd1);
        chk("discard_pending", {31'd0, load_ack}, 32'd0);
        chk("discard_seg", {25'd0, seg}, 32'h7F);

`ifdef SEG7_BLINK_EN
        // phase starts at 1 and flips every 400 cycles; t counts from the first post-reset cycle
        rst = 1'b1;
        step;
        digits = 16'h12AF; dp = '0; blank = '0; blink_mask = 4'b0001; brightness = 2'd3;
        rst = 1'b0;
        load = 1'b1;
        step;
        load = 1'b0;
        for (int t = 0; t < 1664; t++) begin
            if (t == 64)
                chk("blink_ack", {31'd0, load_ack}, 32'd1);
            if (t >= 64 && (t % 64) < 16)
                chk("blink_seg", {25'd0, seg}, ((t / 400) % 2 == 0) ? 32'h0E : 32'h7F);
            step;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
